// File: rtl/banco_registradores_param_if.sv
// Register-file bus: write port, shared read enable, two read ports and the clear-sweep control.
// The testbench drives the master side; the register file takes the slave side.
interface banco_registradores_param_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 2
);
    logic              Esc;
    logic [ADDR_W-1:0] RegEsc;
    logic [WIDTH-1:0]  Dado;
    logic              Ler;
    logic [ADDR_W-1:0] Fonte1;
    logic [ADDR_W-1:0] Fonte2;
    logic              Limpa;
    logic [WIDTH-1:0]  Dado1;
    logic [WIDTH-1:0]  Dado2;
    logic              Valido1;
    logic              Valido2;
    logic              Ocupado;

    modport master (
        output Esc, RegEsc, Dado, Ler, Fonte1, Fonte2, Limpa,
        input  Dado1, Dado2, Valido1, Valido2, Ocupado
    );

    modport slave (
        input  Esc, RegEsc, Dado, Ler, Fonte1, Fonte2, Limpa,
        output Dado1, Dado2, Valido1, Valido2, Ocupado
    );
endinterface

// File: rtl/banco_registradores_param.sv
// Parametrised register file: one write port, two registered read ports, multi-cycle clear sweep.
// Define REG_FORWARD_EN to bypass same-cycle write data to a read of the same index.
module banco_registradores_param #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2
) (
    input logic                       Clk,
    input logic                       Rst,
    banco_registradores_param_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] LIMPA = 1'b1;

    logic [WIDTH-1:0]  regs_q [NUM_REGS];
    logic [WIDTH-1:0]  regs_d [NUM_REGS];
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  dado1_q, dado1_d;
    logic [WIDTH-1:0]  dado2_q, dado2_d;
    logic              valido1_q, valido1_d;
    logic              valido2_q, valido2_d;
    logic [WIDTH-1:0]  rd1, rd2;

    // Read muxes: indices without a register fall through to zero.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.Fonte1 == ADDR_W'(i)) rd1 = regs_q[i];
            if (bus.Fonte2 == ADDR_W'(i)) rd2 = regs_q[i];
`ifdef REG_FORWARD_EN
            if (bus.Esc && bus.RegEsc == ADDR_W'(i) && bus.Fonte1 == ADDR_W'(i)) rd1 = bus.Dado;
            if (bus.Esc && bus.RegEsc == ADDR_W'(i) && bus.Fonte2 == ADDR_W'(i)) rd2 = bus.Dado;
`endif
        end
    end

    always_comb begin
        regs_d    = regs_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        dado1_d   = dado1_q;
        dado2_d   = dado2_q;
        valido1_d = 1'b0;
        valido2_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Esc) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (bus.RegEsc == ADDR_W'(i)) regs_d[i] = bus.Dado;
                    end
                end
                if (bus.Ler) begin
                    dado1_d   = rd1;
                    dado2_d   = rd2;
                    valido1_d = 1'b1;
                    valido2_d = 1'b1;
                end
                if (bus.Limpa) begin
                    state_d = LIMPA;
                    cnt_d   = '0;
                end
            end
            LIMPA: begin
                // Bus requests are ignored here; one register is cleared per cycle.
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (cnt_q == ADDR_W'(i)) regs_d[i] = '0;
                end
                if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            dado1_q   <= '0;
            dado2_q   <= '0;
            valido1_q <= 1'b0;
            valido2_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dado1_q   <= dado1_d;
            dado2_q   <= dado2_d;
            valido1_q <= valido1_d;
            valido2_q <= valido2_d;
        end
    end

    assign bus.Dado1   = dado1_q;
    assign bus.Dado2   = dado2_q;
    assign bus.Valido1 = valido1_q;
    assign bus.Valido2 = valido2_q;
    assign bus.Ocupado = (state_q == LIMPA);
endmodule
